// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem read, 2-entry {pc, instr} FIFO,
// branch redirect with squash of in-flight and buffered work.
module fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic [15:0] pc,
    output logic [15:0] instruction,
    output logic        nop
);

    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] fetch_pc_r;
    logic [15:0] req_pc_r;
    logic [15:0] fifo_pc_r    [0:1];
    logic [15:0] fifo_instr_r [0:1];
    logic [1:0]  count_r;
    logic        empty_s;
    logic        imem_req_s;
    logic        accept_s;
    logic        push_s;
    logic        pop_s;

    // Handshake qualifiers; branch and reset veto every FIFO and memory action
    always_comb begin
        empty_s    = (count_r == 2'd0);
        imem_req_s = (state_r == ST_REQ) && (count_r != 2'd2) && !branch_taken && !reset;
        accept_s   = imem_req_s && imem_ready;
        push_s     = (state_r == ST_WAIT) && imem_rvalid && !branch_taken && !reset;
        pop_s      = !empty_s && !stall && !branch_taken && !reset;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_REQ;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: a response that arrives after a redirect is always dropped
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_REQ: begin
                if (accept_s) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    state_next_s = ST_REQ;
                end else if (branch_taken) begin
                    state_next_s = ST_DISCARD;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DISCARD: begin
                if (imem_rvalid) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_DISCARD;
                end
            end
            default: state_next_s = ST_REQ;
        endcase
    end

    // FSM outputs and presentation path (combinational from the FIFO head)
    always_comb begin
        imem_req  = imem_req_s;
        imem_addr = fetch_pc_r;
        if (reset) begin
            nop         = 1'b1;
            instruction = 16'h0000;
            pc          = 16'h0000;
        end else if (empty_s || branch_taken) begin
            nop         = 1'b1;
            instruction = 16'h0000;
            pc          = fetch_pc_r;
        end else begin
            nop         = 1'b0;
            instruction = fifo_instr_r[0];
            pc          = fifo_pc_r[0];
        end
    end

    // Fetch PC and captured request PC
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r <= 16'h0000;
            req_pc_r   <= 16'h0000;
        end else if (branch_taken) begin
            fetch_pc_r <= branch_target;
        end else if (accept_s) begin
            req_pc_r   <= fetch_pc_r;
            fetch_pc_r <= fetch_pc_r + 16'd1;
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    // Two-entry FIFO kept as a shift register so entry 0 is always the head
    always_ff @(posedge clk) begin
        if (reset || branch_taken) begin
            count_r         <= 2'd0;
            fifo_pc_r[0]    <= 16'h0000;
            fifo_pc_r[1]    <= 16'h0000;
            fifo_instr_r[0] <= 16'h0000;
            fifo_instr_r[1] <= 16'h0000;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        fifo_pc_r[0]    <= req_pc_r;
                        fifo_instr_r[0] <= imem_rdata;
                    end else begin
                        fifo_pc_r[1]    <= req_pc_r;
                        fifo_instr_r[1] <= imem_rdata;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    fifo_pc_r[0]    <= fifo_pc_r[1];
                    fifo_instr_r[0] <= fifo_instr_r[1];
                    count_r         <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        fifo_pc_r[0]    <= req_pc_r;
                        fifo_instr_r[0] <= imem_rdata;
                    end else begin
                        fifo_pc_r[0]    <= fifo_pc_r[1];
                        fifo_instr_r[0] <= fifo_instr_r[1];
                        fifo_pc_r[1]    <= req_pc_r;
                        fifo_instr_r[1] <= imem_rdata;
                    end
                end
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 1-cycle-latency memory model and a scoreboard of
// expected presented PCs, refilled whenever the stimulus redirects the fetch stream.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic [15:0] pc;
    logic [15:0] instruction;
    logic        nop;

    int          errors = 0;
    int          checks = 0;
    int          pops   = 0;
    logic        auto_mem;
    logic [15:0] exp_q [$];

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .pc            (pc),
        .instruction   (instruction),
        .nop           (nop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_seq(input logic [15:0] start, input int n);
        logic [15:0] p;
        exp_q.delete();
        p = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(p);
            p = p + 16'd1;
        end
    endtask

    // One clock cycle: scoreboard the consumed instruction, then answer last cycle's accept
    task automatic tick();
        logic        acc;
        logic [15:0] acc_addr;
        logic [15:0] e;
        @(negedge clk);
        if (nop === 1'b0 && stall === 1'b0 && branch_taken === 1'b0) begin
            chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("present_pc", {16'd0, pc}, {16'd0, e});
                chk("present_instr", {16'd0, instruction}, {16'd0, 16'h1000 + e});
            end
            pops++;
        end
        acc      = (imem_req === 1'b1) && (imem_ready === 1'b1);
        acc_addr = imem_addr;
        @(posedge clk);
        #1;
        if (auto_mem) begin
            imem_rvalid = acc;
            imem_rdata  = acc ? (16'h1000 + acc_addr) : 16'h0000;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 16'h0000;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 16'h0000; auto_mem = 1'b1;
        ticks(2);
        #1;
        chk("rst_nop", {31'd0, nop}, 32'd1);
        chk("rst_instr", {16'd0, instruction}, 32'h0000);
        chk("rst_pc", {16'd0, pc}, 32'h0000);
        chk("rst_req", {31'd0, imem_req}, 32'd0);

        // Streaming fetch after reset release
        reset = 1'b0;
        expect_seq(16'h0000, 16);
        #1;
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        chk("post_rst_addr", {16'd0, imem_addr}, 32'h0000);
        chk("post_rst_nop", {31'd0, nop}, 32'd1);
        chk("post_rst_pc", {16'd0, pc}, 32'h0000);
        ticks(12);
        chk("stream_pops", pops, 32'd5);

        // Stall for four cycles while the FIFO fills
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_pc", {16'd0, pc}, 32'h0005);
            chk("stall_nop", {31'd0, nop}, 32'd0);
            if (i >= 2) chk("stall_req_full", {31'd0, imem_req}, 32'd0);
            tick();
        end
        stall = 1'b0;
        ticks(5);
        auto_mem = 1'b0;
        tick();
        chk("drain_pops", pops, 32'd9);

        // Branch while WAIT; stale response arrives two cycles later
        branch_taken = 1'b1; branch_target = 16'h0040;
        #1;
        chk("br_wait_nop", {31'd0, nop}, 32'd1);
        chk("br_wait_instr", {16'd0, instruction}, 32'h0000);
        chk("br_wait_req", {31'd0, imem_req}, 32'd0);
        expect_seq(16'h0040, 16);
        tick();
        branch_taken = 1'b0;
        #1;
        chk("discard_req", {31'd0, imem_req}, 32'd0);
        chk("discard_pc", {16'd0, pc}, 32'h0040);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 16'hDEAD;
        #1;
        chk("stale_nop", {31'd0, nop}, 32'd1);
        chk("stale_req", {31'd0, imem_req}, 32'd0);
        tick();
        auto_mem = 1'b1;
        #1;
        chk("redir_req", {31'd0, imem_req}, 32'd1);
        chk("redir_addr", {16'd0, imem_addr}, 32'h0040);
        ticks(4);
        chk("redir_pops", pops, 32'd10);

        // Branch coincident with rvalid and stall, FIFO non-empty
        stall = 1'b1;
        #1;
        chk("held_pc", {16'd0, pc}, 32'h0041);
        chk("held_instr", {16'd0, instruction}, 32'h1041);
        tick();
        branch_taken = 1'b1; branch_target = 16'h0100;
        #1;
        chk("br_rv_rvalid_seen", {31'd0, imem_rvalid}, 32'd1);
        chk("br_rv_nop", {31'd0, nop}, 32'd1);
        chk("br_rv_req", {31'd0, imem_req}, 32'd0);
        expect_seq(16'h0100, 16);
        tick();
        branch_taken = 1'b0; stall = 1'b0;
        #1;
        chk("flush_nop", {31'd0, nop}, 32'd1);
        chk("flush_req", {31'd0, imem_req}, 32'd1);
        chk("flush_addr", {16'd0, imem_addr}, 32'h0100);
        ticks(4);
        chk("flush_pops", pops, 32'd11);

        // Branch in REQ with a buffered entry, then wrap 0xFFFF -> 0x0000
        branch_taken = 1'b1; branch_target = 16'hFFFE;
        #1;
        chk("br_req_req", {31'd0, imem_req}, 32'd0);
        chk("br_req_nop", {31'd0, nop}, 32'd1);
        expect_seq(16'hFFFE, 8);
        tick();
        branch_taken = 1'b0;
        #1;
        chk("wrap_addr", {16'd0, imem_addr}, 32'hFFFE);
        chk("wrap_nop", {31'd0, nop}, 32'd1);
        ticks(10);
        chk("wrap_pops", pops, 32'd15);

        // Reset while WAIT, then a stray rvalid pulse
        auto_mem = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("midrst_nop", {31'd0, nop}, 32'd1);
        chk("midrst_pc", {16'd0, pc}, 32'h0000);
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_pops", pops, 32'd16);
        expect_seq(16'h0000, 8);
        tick();
        reset = 1'b0; auto_mem = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 16'hBEEF;
        #1;
        chk("stray_req", {31'd0, imem_req}, 32'd1);
        chk("stray_addr", {16'd0, imem_addr}, 32'h0000);
        chk("stray_nop", {31'd0, nop}, 32'd1);
        tick();
        #1;
        chk("stray_ignored_nop", {31'd0, nop}, 32'd1);
        ticks(5);
        chk("final_pops", pops, 32'd18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
